jk_latch_sequencer: RTL and testbench
=====================================

# jk_latch_sequencer

Command sequencer and two-port arbiter for a bank of level-sensitive JK latches. Accepts HOLD/RESET/SET/TOGGLE commands from two requesters, grants them round-robin, and drives the bank's J/K/En pins with a non-overlapping setup, pulse and close sequence so no latch ever sees J or K change while En is high. After each command it samples the addressed latch's Q and returns it to the requester. It sits between control logic and the `jk_latch` bank.

## Interface

Parameters:
- `N_LATCH`, 4: latches in the bank; power of two, ≥2.
- `IDX_W`, 2: index width, `$clog2(N_LATCH)`.
- `SETUP_CYC`, 1: cycles J/K are stable before En rises; ≥1.
- `PULSE_CYC`, 1: cycles En is high; ≥1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req0_valid` in 1: requester 0 command valid.
- `req0_op` in 2: 00 HOLD (read), 01 RESET, 10 SET, 11 TOGGLE.
- `req0_idx` in IDX_W: target latch.
- `req0_ready` out 1: requester 0 accepted this cycle (valid & ready).
- `req1_valid`, `req1_op`, `req1_idx`, `req1_ready`: same as requester 0, for requester 1.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_src` out 1: requester that issued the responded command.
- `resp_q` out 1: sampled Q of the addressed latch.
- `jk_j` out N_LATCH: J per latch.
- `jk_k` out N_LATCH: K per latch.
- `jk_en` out N_LATCH: En per latch.
- `jk_q` in N_LATCH: Q from the bank.

## Operation

- FSM states: IDLE, SETUP, PULSE, CLOSE, SAMPLE.
- IDLE: arbitrate. If `rst` is high and at least one valid is asserted, assert the winner's ready combinationally. On the accepting edge, latch op, idx and src.
  - HOLD goes to CLOSE.
  - Any other op goes to SETUP.
- Arbitration: round-robin on a 1-bit `last` pointer.
  - Both valid: grant the requester that is not `last`.
  - One valid: grant it.
  - `last` updates to the granted source on each accept.
  - Reset value of `last` is 1, so requester 0 wins the first tie.
- TOGGLE is resolved, never driven as J=K=1: on entry to SETUP, capture `jk_q[idx]`. TOGGLE then drives J=~q, K=q.
- SETUP (SETUP_CYC cycles): J/K of the addressed latch driven per op (RESET J0 K1, SET J1 K0); En=0.
- PULSE (PULSE_CYC cycles): J/K held; `jk_en[idx]`=1.
- CLOSE (1 cycle): En=0; J/K held; `jk_q[idx]` registered into `resp_q` at exit.
- SAMPLE (1 cycle): `resp_valid`=1 with `resp_src`; then go to IDLE.
- Non-addressed latches: J=K=En=0 at all times.
- Requesters have no response backpressure; `resp_valid` is a strobe.
- Reset (`rst`=0 sampled at an edge, including mid-command): state becomes IDLE, the command is dropped, no response is issued, `last`=1.

## Timing

- Reset values: `jk_j`=`jk_k`=`jk_en`=0, `resp_valid`=0, `resp_src`=0, `resp_q`=0. Both readies are 0 while `rst`=0.
- All outputs except readies are registered.
- Latency from accept edge to `resp_valid` high:
  - SET/RESET/TOGGLE: SETUP_CYC+PULSE_CYC+2 cycles (4 at defaults).
  - HOLD: 2 cycles.
- Next accept is the edge ending the first IDLE cycle after SAMPLE. Throughput is one command per SETUP_CYC+PULSE_CYC+3 cycles (5 at defaults), or 3 cycles for HOLD.
- En rises at least SETUP_CYC cycles after J/K change and falls 1 cycle before J/K may change.
- Readies are 0 in every non-IDLE state. Valid held during busy is not accepted and not lost.

## Test plan

- Reset then SET: reset, then req0 SET idx2 → `jk_j`=0100, `jk_k`=0000 for 1 cycle; `jk_en`=0100 for 1 cycle; `resp_valid` 4 cycles after accept with `resp_q`=1 and `resp_src`=0.
- TOGGLE twice: req1 TOGGLE idx0 twice with Q0=0 initially → first drives J1 K0 and `resp_q`=1; second drives J0 K1 and `resp_q`=0. J and K are never both 1.
- Fair arbitration: both valid continuously, req0 HOLD idx1, req1 SET idx3 → grants alternate 0,1,0,1, starting with 0 after reset. Each response's `resp_src` matches its grant.
- HOLD is a pure read: req0 HOLD idx3 → `jk_en` stays 0; `resp_valid` 2 cycles after accept; `resp_q` equals `jk_q[3]`.
- Reset during PULSE: assert `rst`=0 during PULSE → `jk_en`=0 at the next edge, no `resp_valid`, both readies 0 while in reset, and req0 wins the first grant after release.
- Sweep SETUP_CYC=3, PULSE_CYC=2 → `resp_valid` 7 cycles after accept; En is high for exactly 2 cycles.

Source files
------------

// File: rtl/jk_latch_sequencer.sv
// Round-robin command arbiter and non-overlapping J/K/En sequencer for a bank of
// level-sensitive JK latches; returns the addressed latch's Q after every command.
module jk_latch_sequencer #(
  parameter int N_LATCH   = 4,
  parameter int IDX_W     = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [1:0]         req0_op,
  input  logic [IDX_W-1:0]   req0_idx,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [1:0]         req1_op,
  input  logic [IDX_W-1:0]   req1_idx,
  output logic               req1_ready,
  output logic               resp_valid,
  output logic               resp_src,
  output logic               resp_q,
  output logic [N_LATCH-1:0] jk_j,
  output logic [N_LATCH-1:0] jk_k,
  output logic [N_LATCH-1:0] jk_en,
  input  logic [N_LATCH-1:0] jk_q
);

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [N_LATCH-1:0] ONE_HOT0 = N_LATCH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_CLOSE,
    S_SAMPLE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               src_q, src_d;
  logic [N_LATCH-1:0] j_q, j_d;
  logic [N_LATCH-1:0] k_q, k_d;
  logic [N_LATCH-1:0] en_q, en_d;
  logic               respValid_q, respValid_d;
  logic               respSrc_q, respSrc_d;
  logic               respQ_q, respQ_d;

  logic               grantAny;
  logic               grantSrc;
  logic [1:0]         selOp;
  logic [IDX_W-1:0]   selIdx;
  logic [N_LATCH-1:0] selMask;
  logic               selQ;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grantAny   = rst && (state_q == S_IDLE) && (req0_valid || req1_valid);
    grantSrc   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    selOp      = grantSrc ? req1_op  : req0_op;
    selIdx     = grantSrc ? req1_idx : req0_idx;
    selMask    = ONE_HOT0 << selIdx;
    selQ       = jk_q[selIdx];
    req0_ready = grantAny && !grantSrc;
    req1_ready = grantAny &&  grantSrc;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    idx_d       = idx_q;
    src_d       = src_q;
    j_d         = j_q;
    k_d         = k_q;
    en_d        = en_q;
    respValid_d = 1'b0;
    respSrc_d   = respSrc_q;
    respQ_d     = respQ_q;

    case (state_q)
      S_IDLE: begin
        if (grantAny) begin
          last_d  = grantSrc;
          idx_d   = selIdx;
          src_d   = grantSrc;
          cnt_d   = '0;
          state_d = S_SETUP;
          // TOGGLE is resolved from the current Q so J and K are never both high.
          case (selOp)
            OP_HOLD: begin
              j_d     = '0;
              k_d     = '0;
              state_d = S_CLOSE;
            end
            OP_RESET: begin
              j_d = '0;
              k_d = selMask;
            end
            OP_SET: begin
              j_d = selMask;
              k_d = '0;
            end
            OP_TOGGLE: begin
              j_d = selQ ? '0 : selMask;
              k_d = selQ ? selMask : '0;
            end
          endcase
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          en_d    = ONE_HOT0 << idx_q;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          cnt_d   = '0;
          en_d    = '0;
          state_d = S_CLOSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLOSE: begin
        respQ_d = jk_q[idx_q];
        j_d     = '0;
        k_d     = '0;
        state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        respValid_d = 1'b1;
        respSrc_d   = src_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      idx_q       <= '0;
      src_q       <= 1'b0;
      j_q         <= '0;
      k_q         <= '0;
      en_q        <= '0;
      respValid_q <= 1'b0;
      respSrc_q   <= 1'b0;
      respQ_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      src_q       <= src_d;
      j_q         <= j_d;
      k_q         <= k_d;
      en_q        <= en_d;
      respValid_q <= respValid_d;
      respSrc_q   <= respSrc_d;
      respQ_q     <= respQ_d;
    end
  end

  assign jk_j       = j_q;
  assign jk_k       = k_q;
  assign jk_en      = en_q;
  assign resp_valid = respValid_q;
  assign resp_src   = respSrc_q;
  assign resp_q     = respQ_q;

endmodule

// File: tb/tb_jk_latch_sequencer.sv
// Bench for jk_latch_sequencer: a default-parameter instance driving a behavioural
// latch bank with a response scoreboard, plus a SETUP_CYC=3/PULSE_CYC=2 instance.
module tb_jk_latch_sequencer;

  typedef struct {
    bit src;
    bit q;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0Valid = 1'b0;
  logic [1:0] req0Op = 2'b00;
  logic [1:0] req0Idx = 2'd0;
  logic       req0Ready;
  logic       req1Valid = 1'b0;
  logic [1:0] req1Op = 2'b00;
  logic [1:0] req1Idx = 2'd0;
  logic       req1Ready;
  logic       respValid;
  logic       respSrc;
  logic       respQ;
  logic [3:0] jkJ;
  logic [3:0] jkK;
  logic [3:0] jkEn;
  logic [3:0] bankQ = 4'b0000;
  logic       presetEn = 1'b0;
  logic [3:0] presetVal = 4'b0000;

  logic       sReq0Valid = 1'b0;
  logic [1:0] sReq0Op = 2'b00;
  logic [1:0] sReq0Idx = 2'd0;
  logic       sReq0Ready;
  logic       sReq1Valid = 1'b0;
  logic [1:0] sReq1Op = 2'b00;
  logic [1:0] sReq1Idx = 2'd0;
  logic       sReq1Ready;
  logic       sRespValid;
  logic       sRespSrc;
  logic       sRespQ;
  logic [3:0] sJkJ;
  logic [3:0] sJkK;
  logic [3:0] sJkEn;
  logic [3:0] sBankQ = 4'b0000;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   violations = 0;
  exp_t sbQ[$];
  logic [3:0] modelQ = 4'b0000;

  jk_latch_sequencer dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_op(req0Op), .req0_idx(req0Idx), .req0_ready(req0Ready),
    .req1_valid(req1Valid), .req1_op(req1Op), .req1_idx(req1Idx), .req1_ready(req1Ready),
    .resp_valid(respValid), .resp_src(respSrc), .resp_q(respQ),
    .jk_j(jkJ), .jk_k(jkK), .jk_en(jkEn), .jk_q(bankQ)
  );

  jk_latch_sequencer #(.N_LATCH(4), .IDX_W(2), .SETUP_CYC(3), .PULSE_CYC(2)) dutSweep (
    .clk(clk), .rst(rst),
    .req0_valid(sReq0Valid), .req0_op(sReq0Op), .req0_idx(sReq0Idx), .req0_ready(sReq0Ready),
    .req1_valid(sReq1Valid), .req1_op(sReq1Op), .req1_idx(sReq1Idx), .req1_ready(sReq1Ready),
    .resp_valid(sRespValid), .resp_src(sRespSrc), .resp_q(sRespQ),
    .jk_j(sJkJ), .jk_k(sJkK), .jk_en(sJkEn), .jk_q(sBankQ)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural latch banks: Q follows J/K while En is high.
  always @(posedge clk) begin
    if (presetEn) begin
      bankQ <= presetVal;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (jkEn[i]) begin
          if (jkJ[i] && !jkK[i]) bankQ[i] <= 1'b1;
          else if (!jkJ[i] && jkK[i]) bankQ[i] <= 1'b0;
          else if (jkJ[i] && jkK[i]) bankQ[i] <= ~bankQ[i];
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sJkEn[i]) begin
        if (sJkJ[i] && !sJkK[i]) sBankQ[i] <= 1'b1;
        else if (!sJkJ[i] && sJkK[i]) sBankQ[i] <= 1'b0;
        else if (sJkJ[i] && sJkK[i]) sBankQ[i] <= ~sBankQ[i];
      end
    end
  end

  // Scoreboard: predict on accept, compare on response; also watch the bank pins.
  always @(negedge clk) begin : scoreboardMon
    exp_t       e;
    bit         s;
    logic [1:0] op;
    logic [1:0] idx;
    logic [3:0] prevJ;
    logic [3:0] prevK;
    logic [3:0] prevEn;
    logic       prevRst;
    #2;
    if (!rst) begin
      sbQ.delete();
      modelQ = bankQ;
    end else begin
      if (respValid) begin
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: got resp src=%0d q=%0d at cycle %0d, expected no response",
                   respSrc, respQ, cyc);
        end else begin
          e = sbQ.pop_front();
          if (respSrc !== e.src || respQ !== e.q || cyc != e.due) begin
            errors++;
            $display("[TB] FAIL sb_resp: got src=%0d q=%0d cycle=%0d, expected src=%0d q=%0d cycle=%0d",
                     respSrc, respQ, cyc, e.src, e.q, e.due);
          end
        end
      end
      if (req0Ready || req1Ready) begin
        s   = req1Ready;
        op  = s ? req1Op : req0Op;
        idx = s ? req1Idx : req0Idx;
        case (op)
          2'b01:   modelQ[idx] = 1'b0;
          2'b10:   modelQ[idx] = 1'b1;
          2'b11:   modelQ[idx] = ~modelQ[idx];
          default: ;
        endcase
        e.src = s;
        e.q   = modelQ[idx];
        e.due = cyc + 1 + ((op == 2'b00) ? 2 : 4);
        sbQ.push_back(e);
      end
    end
    if (rst && prevRst) begin
      if ((jkJ & jkK) != 4'b0000) begin
        violations++;
        $display("[TB] protocol violation: J and K both high, j=%b k=%b", jkJ, jkK);
      end
      if ((jkEn != 4'b0000 || prevEn != 4'b0000) && (jkJ != prevJ || jkK != prevK)) begin
        violations++;
        $display("[TB] protocol violation: J/K changed around En, j=%b k=%b en=%b", jkJ, jkK, jkEn);
      end
      if ($countones(jkJ | jkK | jkEn) > 1) begin
        violations++;
        $display("[TB] protocol violation: more than one latch driven, j=%b k=%b en=%b", jkJ, jkK, jkEn);
      end
    end
    prevJ   = jkJ;
    prevK   = jkK;
    prevEn  = jkEn;
    prevRst = rst;
  end

  task automatic doReset(input logic [3:0] preset);
    @(negedge clk);
    rst = 1'b0; req0Valid = 1'b0; req1Valid = 1'b0; presetEn = 1'b1; presetVal = preset;
    @(negedge clk);
    presetEn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; presetEn = 1'b1; presetVal = 4'b0000;
    req0Valid = 1'b1; req0Op = 2'b10; req0Idx = 2'd1;
    req1Valid = 1'b1; req1Op = 2'b01; req1Idx = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (i == 1) presetEn = 1'b0;
      checks++;
      if ({jkJ, jkK, jkEn} !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_pins: got j=%b k=%b en=%b, expected all 0000", jkJ, jkK, jkEn);
      end
      checks++;
      if (respValid !== 1'b0 || respSrc !== 1'b0 || respQ !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_resp: got valid=%0d src=%0d q=%0d, expected 0 0 0", respValid, respSrc, respQ);
      end
      checks++;
      if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ready: got ready0=%0d ready1=%0d, expected 0 0", req0Ready, req1Ready);
      end
    end
    req0Valid = 1'b0; req1Valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_set_sequence();
    int waitCyc;
    @(negedge clk);
    req0Valid = 1'b1; req0Op = 2'b10; req0Idx = 2'd2;
    #1;
    waitCyc = 0;
    while (!req0Ready && waitCyc < 20) begin
      @(negedge clk); #1; waitCyc++;
    end
    checks++;
    if (req0Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_grant: got ready0=%0d after %0d cycles, expected 1", req0Ready, waitCyc);
    end
    @(negedge clk);
    req0Valid = 1'b0;
    #1;
    checks++;
    if (jkJ !== 4'b0100 || jkK !== 4'b0000 || jkEn !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL set_setup: got j=%b k=%b en=%b, expected j=0100 k=0000 en=0000", jkJ, jkK, jkEn);
    end
    @(negedge clk); #1;
    checks++;
    if (jkJ !== 4'b0100 || jkK !== 4'b0000 || jkEn !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL set_pulse: got j=%b k=%b en=%b, expected j=0100 k=0000 en=0100", jkJ, jkK, jkEn);
    end
    @(negedge clk); #1;
    checks++;
    if (jkJ !== 4'b0100 || jkEn !== 4'b0000 || respValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL set_close: got j=%b en=%b valid=%0d, expected j=0100 en=0000 valid=0", jkJ, jkEn, respValid);
    end
    @(negedge clk); #1;
    checks++;
    if (jkJ !== 4'b0000 || respValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL set_sample: got j=%b valid=%0d, expected j=0000 valid=0", jkJ, respValid);
    end
    @(negedge clk); #1;
    checks++;
    if (respValid !== 1'b1 || respQ !== 1'b1 || respSrc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL set_resp: got valid=%0d q=%0d src=%0d, expected 1 1 0", respValid, respQ, respSrc);
    end
  endtask

  task automatic test_toggle_twice();
    int  waitCyc;
    bit  busyReady;
    @(negedge clk);
    req1Valid = 1'b1; req1Op = 2'b11; req1Idx = 2'd0;
    #1;
    waitCyc = 0;
    while (!req1Ready && waitCyc < 20) begin
      @(negedge clk); #1; waitCyc++;
    end
    checks++;
    if (req1Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL toggle_grant: got ready1=%0d, expected 1", req1Ready);
    end
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (n == 1) req1Valid = 1'b0;
      #1;
      checks++;
      if (jkJ !== ((n == 0) ? 4'b0001 : 4'b0000) || jkK !== ((n == 0) ? 4'b0000 : 4'b0001)) begin
        errors++;
        $display("[TB] FAIL toggle_setup_%0d: got j=%b k=%b, expected j=%b k=%b", n, jkJ, jkK,
                 (n == 0) ? 4'b0001 : 4'b0000, (n == 0) ? 4'b0000 : 4'b0001);
      end
      busyReady = req1Ready;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); #1;
        busyReady = busyReady | req1Ready;
      end
      checks++;
      if (busyReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL toggle_busy_ready_%0d: got ready1=1 while busy, expected 0", n);
      end
      @(negedge clk); #1;
      checks++;
      if (respValid !== 1'b1 || respQ !== ((n == 0) ? 1'b1 : 1'b0) || respSrc !== 1'b1) begin
        errors++;
        $display("[TB] FAIL toggle_resp_%0d: got valid=%0d q=%0d src=%0d, expected 1 %0d 1",
                 n, respValid, respQ, respSrc, (n == 0) ? 1 : 0);
      end
      if (n == 0) begin
        checks++;
        if (req1Ready !== 1'b1) begin
          errors++;
          $display("[TB] FAIL toggle_rearm: got ready1=%0d in first idle cycle, expected 1", req1Ready);
        end
      end
    end
  endtask

  task automatic test_fair_arbitration();
    bit grants[$];
    int waitCyc;
    doReset(4'b0000);
    @(negedge clk);
    req0Valid = 1'b1; req0Op = 2'b00; req0Idx = 2'd1;
    req1Valid = 1'b1; req1Op = 2'b10; req1Idx = 2'd3;
    #1;
    waitCyc = 0;
    while (waitCyc < 60) begin
      if (req0Ready) grants.push_back(1'b0);
      else if (req1Ready) grants.push_back(1'b1);
      if (grants.size() == 4) break;
      @(negedge clk); #1; waitCyc++;
    end
    @(negedge clk);
    req0Valid = 1'b0; req1Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= grants.size()) begin
        errors++;
        $display("[TB] FAIL fair_grant_%0d: got no grant, expected src %0d", i, i % 2);
      end else if (grants[i] !== bit'(i % 2)) begin
        errors++;
        $display("[TB] FAIL fair_grant_%0d: got src %0d, expected src %0d", i, grants[i], i % 2);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_hold_read();
    int waitCyc;
    doReset(4'b1000);
    @(negedge clk);
    req0Valid = 1'b1; req0Op = 2'b00; req0Idx = 2'd3;
    #1;
    waitCyc = 0;
    while (!req0Ready && waitCyc < 20) begin
      @(negedge clk); #1; waitCyc++;
    end
    checks++;
    if (req0Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_grant: got ready0=%0d, expected 1", req0Ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) req0Valid = 1'b0;
      #1;
      checks++;
      if (jkEn !== 4'b0000 || jkJ !== 4'b0000 || jkK !== 4'b0000 || respValid !== (k == 2)) begin
        errors++;
        $display("[TB] FAIL hold_cycle_%0d: got en=%b j=%b k=%b valid=%0d, expected 0000 0000 0000 %0d",
                 k, jkEn, jkJ, jkK, respValid, (k == 2) ? 1 : 0);
      end
    end
    checks++;
    if (respQ !== 1'b1 || respSrc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_resp: got q=%0d src=%0d, expected q=1 src=0", respQ, respSrc);
    end
  endtask

  task automatic test_reset_during_pulse();
    int waitCyc;
    @(negedge clk);
    req0Valid = 1'b1; req0Op = 2'b10; req0Idx = 2'd1;
    #1;
    waitCyc = 0;
    while (!req0Ready && waitCyc < 20) begin
      @(negedge clk); #1; waitCyc++;
    end
    @(negedge clk);
    req0Valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (jkEn !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL rstp_pulse: got en=%b, expected 0010", jkEn);
    end
    rst = 1'b0;
    req0Valid = 1'b1; req0Op = 2'b00; req0Idx = 2'd0;
    req1Valid = 1'b1; req1Op = 2'b00; req1Idx = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (jkEn !== 4'b0000 || jkJ !== 4'b0000 || respValid !== 1'b0 || req0Ready !== 1'b0 || req1Ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rstp_in_reset_%0d: got en=%b j=%b valid=%0d rdy0=%0d rdy1=%0d, expected 0000 0000 0 0 0",
                 i, jkEn, jkJ, respValid, req0Ready, req1Ready);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstp_first_grant: got rdy0=%0d rdy1=%0d, expected 1 0", req0Ready, req1Ready);
    end
    @(negedge clk);
    req0Valid = 1'b0; req1Valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_sweep();
    int         waitCyc;
    int         k;
    int         enCount;
    int         enFirst;
    bit         seen;
    logic [3:0] firstJ;
    @(negedge clk);
    sReq0Valid = 1'b1; sReq0Op = 2'b10; sReq0Idx = 2'd1;
    #1;
    waitCyc = 0;
    while (!sReq0Ready && waitCyc < 20) begin
      @(negedge clk); #1; waitCyc++;
    end
    checks++;
    if (sReq0Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sweep_grant: got ready0=%0d, expected 1", sReq0Ready);
    end
    enCount = 0; enFirst = -1; seen = 1'b0; k = 0; firstJ = 4'b0000;
    @(negedge clk);
    sReq0Valid = 1'b0;
    #1;
    while (k < 20) begin
      if (k == 0) firstJ = sJkJ;
      if (sJkEn != 4'b0000) begin
        enCount++;
        if (enFirst < 0) enFirst = k;
      end
      if (sRespValid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1; k++;
    end
    checks++;
    if (!seen || k != 7) begin
      errors++;
      $display("[TB] FAIL sweep_latency: got seen=%0d latency=%0d, expected seen=1 latency=7", seen, k);
    end
    checks++;
    if (enCount != 2 || enFirst != 3) begin
      errors++;
      $display("[TB] FAIL sweep_en: got high=%0d first=%0d, expected high=2 first=3", enCount, enFirst);
    end
    checks++;
    if (firstJ !== 4'b0010 || sRespQ !== 1'b1 || sRespSrc !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_data: got j=%b q=%0d src=%0d, expected j=0010 q=1 src=0", firstJ, sRespQ, sRespSrc);
    end
  endtask

  task automatic test_final();
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (violations != 0) begin
      errors++;
      $display("[TB] FAIL pin_protocol: got %0d violations, expected 0", violations);
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d outstanding responses, expected 0", sbQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_set_sequence();
    test_toggle_twice();
    test_fair_arbitration();
    test_hold_read();
    test_reset_during_pulse();
    test_sweep();
    test_final();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by 100000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
